// File: rtl/mem_master_pkg.sv
// Shared definitions for the memory initiator: FSM state encoding,
// default bus widths and the instruction-word field layout used by the core.
package mem_master_pkg;

    // Default address and data widths of the single-port memory bus
    localparam int AW_DEF = 12;
    localparam int DW_DEF = 12;

    // Instruction-word field positions shared with the accumulator core
    localparam int OPC_MSB  = 11;
    localparam int OPC_LSB  = 9;
    localparam int IND_BIT  = 8;
    localparam int PAGE_BIT = 7;
    localparam int OFF_MSB  = 6;
    localparam int OFF_LSB  = 0;

    localparam int OPC_W = OPC_MSB - OPC_LSB + 1;
    localparam int OFF_W = OFF_MSB - OFF_LSB + 1;

    // Request sequencing: IDLE -> [PTR] -> ACCESS -> RESP -> IDLE
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PTR    = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Field extractors for a 12-bit instruction word
    function automatic logic [OPC_W-1:0] instr_opcode(input logic [11:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic instr_indirect(input logic [11:0] instr);
        return instr[IND_BIT];
    endfunction

    function automatic logic instr_page(input logic [11:0] instr);
        return instr[PAGE_BIT];
    endfunction

    function automatic logic [OFF_W-1:0] instr_offset(input logic [11:0] instr);
        return instr[OFF_MSB:OFF_LSB];
    endfunction

endpackage

// File: rtl/mem_master.sv
// Initiator for the single-port memory: accepts one load/store at a time,
// resolves one level of indirection with a pointer read, drives the memory
// strobes and returns the result over a response handshake.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    // request channel
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic          req_indirect,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    // response channel
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] rsp_ea,
    // memory port
    output logic          rden,
    output logic          wren,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] writeData,
    input  logic [DW-1:0] readData
);

    state_t        state_q;
    logic          write_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] ea_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] data_q;
    logic          req_ready_q;
    logic          rsp_valid_q;

    // Sequencer and datapath registers; handshake flags are registered
    // alongside the state so they change on the same edge as the state.
    // readData is only captured in PTR and load-ACCESS, the only cycles
    // in which rden is driven high, so a floating bus is never latched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            ea_q        <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q     <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (req_indirect) begin
                            state_q <= PTR;
                        end else begin
                            ea_q    <= req_addr;
                            state_q <= ACCESS;
                        end
                    end
                end
                PTR: begin
                    // pointer value is used verbatim, no further nesting
                    ea_q    <= readData[AW-1:0];
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    data_q      <= write_q ? wdata_q : readData;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Memory strobes decoded from state only; bus is idle (all zero)
    // outside PTR and ACCESS, and rden/wren are mutually exclusive.
    always_comb begin
        rden      = 1'b0;
        wren      = 1'b0;
        addr      = '0;
        writeData = '0;
        case (state_q)
            PTR: begin
                rden = 1'b1;
                addr = addr_q;
            end
            ACCESS: begin
                rden      = ~write_q;
                wren      = write_q;
                addr      = ea_q;
                writeData = wdata_q;
            end
            default: begin
            end
        endcase
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = data_q;
    assign rsp_ea    = ea_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a behavioural 4K x 12 memory model.
module tb_mem_master;

    localparam int AW = 12;
    localparam int DW = 12;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic          req_indirect;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_ea;
    logic          rden;
    logic          wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] writeData;
    wire  [DW-1:0] readData;

    logic [DW-1:0] mem  [0:4095];
    logic [DW-1:0] snap [0:4095];
    logic          mem_load;

    int n_cmp;
    int n_err;

    mem_master #(.AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_indirect (req_indirect),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_ea       (rsp_ea),
        .rden         (rden),
        .wren         (wren),
        .addr         (addr),
        .writeData    (writeData),
        .readData     (readData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read while rden, floating otherwise
    assign readData = rden ? mem[addr] : {DW{1'bz}};

    // Memory image load and write port; memory ignores the master's reset
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
            mem[125] <= 12'd100;
            mem[126] <= 12'd200;
            mem[200] <= 12'd10;
        end else if (wren) begin
            mem[addr] <= writeData;
        end
    end

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one request for a single edge (DUT is in IDLE), then drop it
    task automatic issue(input logic w, input logic ind, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd);
        req_valid    = 1'b1;
        req_write    = w;
        req_indirect = ind;
        req_addr     = a;
        req_wdata    = wd;
        tick();
        req_valid    = 1'b0;
    endtask

    initial begin
        int diffs;
        int seen;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        mem_load = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_indirect = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_load = 1'b0;
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_ea", rsp_ea, 0);
        check_eq("rst_rden", rden, 0);
        check_eq("rst_wren", wren, 0);
        check_eq("rst_addr", addr, 0);
        check_eq("rst_writeData", writeData, 0);
        rst = 1'b1;
        tick();

        // direct load of 125
        issue(1'b0, 1'b0, 12'd125, 12'd0);
        check_eq("dload_c1_rden", rden, 1);
        check_eq("dload_c1_wren", wren, 0);
        check_eq("dload_c1_addr", addr, 125);
        check_eq("dload_c1_rsp_valid", rsp_valid, 0);
        tick();
        check_eq("dload_c2_rsp_valid", rsp_valid, 1);
        check_eq("dload_c2_rsp_data", rsp_data, 100);
        check_eq("dload_c2_rsp_ea", rsp_ea, 125);
        check_eq("dload_c2_req_ready", req_ready, 0);
        check_eq("dload_c2_rden", rden, 0);
        tick();
        check_eq("dload_idle_req_ready", req_ready, 1);
        check_eq("dload_idle_rsp_valid", rsp_valid, 0);

        // direct store 5A5 to 300, then load it back
        issue(1'b1, 1'b0, 12'd300, 12'h5A5);
        check_eq("dstore_wren", wren, 1);
        check_eq("dstore_rden", rden, 0);
        check_eq("dstore_addr", addr, 300);
        check_eq("dstore_writeData", writeData, 12'h5A5);
        tick();
        check_eq("dstore_wren_off", wren, 0);
        check_eq("dstore_rsp_data", rsp_data, 12'h5A5);
        check_eq("dstore_rsp_ea", rsp_ea, 300);
        tick();
        check_eq("dstore_mem300", mem[300], 12'h5A5);
        issue(1'b0, 1'b0, 12'd300, 12'd0);
        tick();
        check_eq("reload_rsp_data", rsp_data, 12'h5A5);
        tick();

        // indirect load: mem[50] = 200 -> mem[200] = 10
        issue(1'b1, 1'b0, 12'd50, 12'd200);
        tick();
        tick();
        issue(1'b0, 1'b1, 12'd50, 12'd0);
        check_eq("iload_ptr_rden", rden, 1);
        check_eq("iload_ptr_addr", addr, 50);
        check_eq("iload_ptr_rsp_valid", rsp_valid, 0);
        tick();
        check_eq("iload_acc_rden", rden, 1);
        check_eq("iload_acc_addr", addr, 200);
        check_eq("iload_acc_rsp_valid", rsp_valid, 0);
        tick();
        check_eq("iload_rsp_valid", rsp_valid, 1);
        check_eq("iload_rsp_data", rsp_data, 10);
        check_eq("iload_rsp_ea", rsp_ea, 200);
        tick();

        // indirect store 7 via 50, then direct load of 200
        issue(1'b1, 1'b1, 12'd50, 12'd7);
        check_eq("istore_ptr_wren", wren, 0);
        check_eq("istore_ptr_addr", addr, 50);
        tick();
        check_eq("istore_acc_wren", wren, 1);
        check_eq("istore_acc_rden", rden, 0);
        check_eq("istore_acc_addr", addr, 200);
        check_eq("istore_acc_writeData", writeData, 7);
        tick();
        check_eq("istore_rsp_data", rsp_data, 7);
        check_eq("istore_rsp_ea", rsp_ea, 200);
        tick();
        issue(1'b0, 1'b0, 12'd200, 12'd0);
        tick();
        check_eq("istore_reload", rsp_data, 7);
        tick();

        // back-pressure on a load of 126 with a competing request pending
        rsp_ready = 1'b0;
        issue(1'b0, 1'b0, 12'd126, 12'd0);
        tick();
        req_valid    = 1'b1;
        req_write    = 1'b1;
        req_indirect = 1'b0;
        req_addr     = 12'd5;
        req_wdata    = 12'h123;
        for (int c = 0; c < 3; c++) begin
            check_eq($sformatf("bp%0d_rsp_valid", c), rsp_valid, 1);
            check_eq($sformatf("bp%0d_rsp_data", c), rsp_data, 200);
            check_eq($sformatf("bp%0d_rsp_ea", c), rsp_ea, 126);
            check_eq($sformatf("bp%0d_req_ready", c), req_ready, 0);
            if (c < 2) tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check_eq("bp_release_req_ready", req_ready, 1);
        check_eq("bp_release_rsp_valid", rsp_valid, 0);
        tick();
        check_eq("bp_no_accept_wren", wren, 0);
        check_eq("bp_no_accept_rden", rden, 0);
        check_eq("bp_no_accept_mem5", mem[5], 0);

        // reset during PTR of an indirect load
        issue(1'b0, 1'b1, 12'd50, 12'd0);
        check_eq("rstmid_in_ptr", rden, 1);
        for (int i = 0; i < 4096; i++) snap[i] = mem[i];
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_eq("rstmid_rden", rden, 0);
        check_eq("rstmid_wren", wren, 0);
        check_eq("rstmid_rsp_valid", rsp_valid, 0);
        check_eq("rstmid_req_ready", req_ready, 1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid) seen++;
            tick();
        end
        check_eq("rstmid_no_response", seen, 0);
        diffs = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== snap[i]) diffs++;
        check_eq("rstmid_mem_unchanged", diffs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
